// File: rtl/seg_scan_ctrl.sv
// Multiplexed common-anode 7-segment scanner: one digit per tick, values double-buffered
// and swapped in only when the scan wraps, so a frame never shows a mix of old and new digits.
module seg_scan_ctrl #(
    parameter int N_DIGITS    = 6,
    parameter int CLK_HZ      = 50000000,
    parameter int SCAN_HZ     = 1000,
    parameter bit COM_ACT_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  nRESET,
    input  logic                  enable,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] value_in,
    input  logic [N_DIGITS-1:0]   dp_mask,
    input  logic                  hex_mode,
    input  logic                  blank_lz,
    output logic [N_DIGITS-1:0]   SEG_COM,
    output logic [7:0]            SEG_DATA,
    output logic                  frame_done
);
    localparam int DIV   = CLK_HZ / SCAN_HZ;
    localparam int CNT_W = $clog2(DIV);
    localparam int IDX_W = $clog2(N_DIGITS);
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0] COM_OFF  = {N_DIGITS{COM_ACT_LOW}};

    logic [CNT_W-1:0]      div_cnt_reg, div_cnt_next;
    logic [IDX_W-1:0]      digit_idx_reg, digit_idx_next;
    logic                  scan_on_reg, scan_on_next;
    logic [4*N_DIGITS-1:0] pending_val_reg, shadow_val_reg, shadow_val_next;
    logic [N_DIGITS-1:0]   pending_dp_reg, shadow_dp_reg, shadow_dp_next;
    logic [N_DIGITS-1:0]   com_next;
    logic [7:0]            data_next;
    logic [N_DIGITS-1:0]   lz_blank;
    logic                  zero_run;
    logic                  tick;
    logic                  wrap;
    logic [3:0]            nib [N_DIGITS];

    function automatic logic [6:0] seg_decode(input logic [3:0] n, input logic hex);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b1111110;
            4'h1: s = 7'b0110000;
            4'h2: s = 7'b1101101;
            4'h3: s = 7'b1111001;
            4'h4: s = 7'b0110011;
            4'h5: s = 7'b1011011;
            4'h6: s = 7'b1011111;
            4'h7: s = 7'b1110000;
            4'h8: s = 7'b1111111;
            4'h9: s = 7'b1111011;
            4'hA: s = 7'b1110111;
            4'hB: s = 7'b0011111;
            4'hC: s = 7'b1001110;
            4'hD: s = 7'b0111101;
            4'hE: s = 7'b1001111;
            default: s = 7'b1000111;
        endcase
        if (!hex && n > 4'd9)
            s = 7'b0000000;
        return s;
    endfunction

    assign tick = enable && (div_cnt_reg == CNT_LAST);
    assign wrap = tick && scan_on_reg && (digit_idx_reg == IDX_LAST);

    // The first tick after enable only lights digit 0; later ticks advance the scan.
    always_comb begin
        div_cnt_next   = div_cnt_reg;
        digit_idx_next = digit_idx_reg;
        scan_on_next   = scan_on_reg;
        if (!enable) begin
            div_cnt_next   = '0;
            digit_idx_next = '0;
            scan_on_next   = 1'b0;
        end else begin
            div_cnt_next = (div_cnt_reg == CNT_LAST) ? '0 : div_cnt_reg + 1'b1;
            if (tick) begin
                scan_on_next = 1'b1;
                if (scan_on_reg)
                    digit_idx_next = (digit_idx_reg == IDX_LAST) ? '0 : digit_idx_reg + 1'b1;
            end
        end
    end

    // A load landing on the wrap tick bypasses pending so it shows in the frame starting now.
    always_comb begin
        shadow_val_next = shadow_val_reg;
        shadow_dp_next  = shadow_dp_reg;
        if (wrap) begin
            shadow_val_next = load ? value_in : pending_val_reg;
            shadow_dp_next  = load ? dp_mask  : pending_dp_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_DIGITS; gi++) begin : g_nib
            assign nib[gi] = shadow_val_next[4*gi +: 4];
        end
    endgenerate

    always_comb begin
        lz_blank = '0;
        zero_run = 1'b1;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            zero_run    = zero_run && (nib[i] == 4'd0);
            lz_blank[i] = blank_lz && zero_run && (i != 0);
        end
    end

    // Outputs are decoded from next-state index/shadow so registers line up with the scan.
    always_comb begin
        com_next  = COM_OFF;
        data_next = 8'd0;
        if (scan_on_next) begin
            for (int i = 0; i < N_DIGITS; i++) begin
                if (digit_idx_next == IDX_W'(i)) begin
                    com_next[i] = !COM_ACT_LOW;
                    data_next   = {lz_blank[i] ? 7'd0 : seg_decode(nib[i], hex_mode),
                                   shadow_dp_next[i]};
                end
            end
        end
    end

    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            div_cnt_reg     <= '0;
            digit_idx_reg   <= '0;
            scan_on_reg     <= 1'b0;
            pending_val_reg <= '0;
            pending_dp_reg  <= '0;
            shadow_val_reg  <= '0;
            shadow_dp_reg   <= '0;
            SEG_COM         <= COM_OFF;
            SEG_DATA        <= 8'd0;
            frame_done      <= 1'b0;
        end else begin
            div_cnt_reg    <= div_cnt_next;
            digit_idx_reg  <= digit_idx_next;
            scan_on_reg    <= scan_on_next;
            shadow_val_reg <= shadow_val_next;
            shadow_dp_reg  <= shadow_dp_next;
            if (load) begin
                pending_val_reg <= value_in;
                pending_dp_reg  <= dp_mask;
            end
            SEG_COM    <= com_next;
            SEG_DATA   <= data_next;
            frame_done <= wrap;
        end
    end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with DIV=4, six digits, active-low commons.
module tb_seg_scan_ctrl;
    logic        clk = 1'b0;
    logic        nRESET;
    logic        enable;
    logic        load;
    logic [23:0] value_in;
    logic [5:0]  dp_mask;
    logic        hex_mode;
    logic        blank_lz;
    logic [5:0]  SEG_COM;
    logic [7:0]  SEG_DATA;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    localparam logic [6:0] S0 = 7'b1111110, S1 = 7'b0110000, S2 = 7'b1101101;
    localparam logic [6:0] S3 = 7'b1111001, S4 = 7'b0110011, S5 = 7'b1011011;
    localparam logic [6:0] S6 = 7'b1011111, S7 = 7'b1110000, SA = 7'b1110111;
    localparam logic [6:0] SB = 7'b0011111, SC = 7'b1001110, SF = 7'b1000111;
    localparam logic [6:0] SX = 7'b0000000;

    seg_scan_ctrl #(.N_DIGITS(6), .CLK_HZ(1000), .SCAN_HZ(250), .COM_ACT_LOW(1'b1)) dut (
        .clk(clk), .nRESET(nRESET), .enable(enable), .load(load),
        .value_in(value_in), .dp_mask(dp_mask), .hex_mode(hex_mode), .blank_lz(blank_lz),
        .SEG_COM(SEG_COM), .SEG_DATA(SEG_DATA), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [23:0] v, input logic [5:0] dp);
        load     = 1'b1;
        value_in = v;
        dp_mask  = dp;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_fd(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_done !== 1'b1 && n < 200);
        chk({tag, " frame_done wait"}, 48'(frame_done), 48'd1);
    endtask

    function automatic logic [47:0] frame(input logic [6:0] s5, input logic [6:0] s4,
                                          input logic [6:0] s3, input logic [6:0] s2,
                                          input logic [6:0] s1, input logic [6:0] s0,
                                          input logic [5:0] dp);
        return {s5, dp[5], s4, dp[4], s3, dp[3], s2, dp[2], s1, dp[1], s0, dp[0]};
    endfunction

    task automatic chk_digit(input string tag, input int d, input logic [7:0] exp_data);
        logic [5:0] exp_com;
        exp_com = 6'b111111 ^ (6'b000001 << d);
        $display("check %s digit %0d: com=%b data=%b", tag, d, SEG_COM, SEG_DATA);
        chk($sformatf("%s d%0d com", tag, d), 48'(SEG_COM), 48'(exp_com));
        chk($sformatf("%s d%0d data", tag, d), 48'(SEG_DATA), 48'(exp_data));
    endtask

    // Starts on a frame_done cycle and returns on the last cycle of digit 5.
    task automatic check_frame(input string tag, input logic [47:0] exp);
        for (int d = 0; d < 6; d++) begin
            chk_digit({tag, " start"}, d, exp[8*d +: 8]);
            chk($sformatf("%s d%0d fd", tag, d), 48'(frame_done), (d == 0) ? 48'd1 : 48'd0);
            step(3);
            chk_digit({tag, " end"}, d, exp[8*d +: 8]);
            chk($sformatf("%s d%0d fd late", tag, d), 48'(frame_done), 48'd0);
            if (d < 5)
                step(1);
        end
    endtask

    initial begin
        nRESET = 1'b0; enable = 1'b0; load = 1'b0; value_in = '0; dp_mask = '0;
        hex_mode = 1'b0; blank_lz = 1'b0;
        step(3);
        chk("reset com", 48'(SEG_COM), 48'h3F);
        chk("reset data", 48'(SEG_DATA), 48'h00);
        chk("reset fd", 48'(frame_done), 48'd0);
        nRESET = 1'b1;
        step(1);
        chk("idle com", 48'(SEG_COM), 48'h3F);

        // Basic decimal scan
        enable = 1'b1;
        do_load(24'h123456, 6'b0);
        chk("dark after enable", 48'(SEG_COM), 48'h3F);
        wait_fd("t1");
        check_frame("t1", frame(S1, S2, S3, S4, S5, S6, 6'b0));

        // Hex digits, then the same digits blanked in decimal mode
        hex_mode = 1'b1;
        wait_fd("t2 pre");
        do_load(24'h00ABCF, 6'b0);
        wait_fd("t2");
        check_frame("t2 hex", frame(S0, S0, SA, SB, SC, SF, 6'b0));
        hex_mode = 1'b0;
        wait_fd("t2 dec");
        check_frame("t2 dec", frame(S0, S0, SX, SX, SX, SX, 6'b0));

        // Leading-zero blanking
        blank_lz = 1'b1;
        wait_fd("t3 pre");
        do_load(24'h000070, 6'b0);
        wait_fd("t3");
        check_frame("t3 lz70", frame(SX, SX, SX, SX, S7, S0, 6'b0));
        wait_fd("t3 pre0");
        do_load(24'h000000, 6'b0);
        wait_fd("t3 zero");
        check_frame("t3 lz0", frame(SX, SX, SX, SX, SX, S0, 6'b0));

        // Decimal point survives blanking
        wait_fd("t5 pre");
        do_load(24'h000005, 6'b000100);
        wait_fd("t5");
        check_frame("t5 dp", frame(SX, SX, SX, SX, SX, S5, 6'b000100));

        // Mid-frame load waits for the next frame
        blank_lz = 1'b0;
        wait_fd("t4 pre");
        do_load(24'h123456, 6'b0);
        wait_fd("t4");
        chk_digit("t4 base", 0, {S6, 1'b0});
        step(8);
        do_load(24'h111111, 6'b0);
        chk_digit("t4 old", 2, {S4, 1'b0});
        step(3);
        chk_digit("t4 old", 3, {S3, 1'b0});
        step(4);
        chk_digit("t4 old", 4, {S2, 1'b0});
        step(4);
        chk_digit("t4 old", 5, {S1, 1'b0});
        wait_fd("t4 new");
        chk_digit("t4 new", 0, {S1, 1'b0});

        // Load on the wrap tick bypasses pending and also updates pending
        step(1);
        do_load(24'h222222, 6'b0);
        step(21);
        do_load(24'h333333, 6'b0);
        chk("t4 bypass fd", 48'(frame_done), 48'd1);
        chk_digit("t4 bypass", 0, {S3, 1'b0});
        step(4);
        chk_digit("t4 bypass", 1, {S3, 1'b0});
        wait_fd("t4 keep");
        chk_digit("t4 keep", 0, {S3, 1'b0});

        // Enable drop and restart
        step(6);
        enable = 1'b0;
        step(1);
        chk("t6 off com", 48'(SEG_COM), 48'h3F);
        chk("t6 off data", 48'(SEG_DATA), 48'h00);
        step(3);
        chk("t6 still off", 48'(SEG_COM), 48'h3F);
        enable = 1'b1;
        step(3);
        chk("t6 dark before tick", 48'(SEG_COM), 48'h3F);
        step(1);
        chk_digit("t6 restart", 0, {S3, 1'b0});
        chk("t6 restart fd", 48'(frame_done), 48'd0);
        step(4);
        chk_digit("t6 restart", 1, {S3, 1'b0});

        // Asynchronous reset mid-frame drops pending and shadow
        step(2);
        nRESET = 1'b0;
        #1;
        chk("t6 async com", 48'(SEG_COM), 48'h3F);
        chk("t6 async data", 48'(SEG_DATA), 48'h00);
        chk("t6 async fd", 48'(frame_done), 48'd0);
        @(negedge clk);
        nRESET = 1'b1;
        wait_fd("t6 post");
        check_frame("t6 post", frame(S0, S0, S0, S0, S0, S0, 6'b0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
